data_mem_lsu: RTL and testbench
===============================

# data_mem_lsu

Parametrised data memory with a valid/ready request port, sub-word load/store support (byte/halfword/word, signed and unsigned), little-endian byte-lane writes, configurable wait states and alignment/range error reporting. It sits in the MEM stage of the 5-stage pipeline. The request handshake gives the hazard unit a real stall source, so stall and flush paths can be exercised against a non-zero-latency memory.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; power of two, 16..4096
- WAIT_STATES, 0, extra cycles between request acceptance and completion; 0..15

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 of the load/store instruction
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bits used for SB/SH
- resp_valid  out  1  one-cycle pulse marking a completed request
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  request was illegal, misaligned or out of range

## Operation
- FSM states are IDLE, WAIT and RESP. Reset enters IDLE.
- req_ready is high in IDLE and RESP and low in WAIT.
- Accept: a request is accepted on a rising edge where req_valid and req_ready are both high. The block captures we, funct3, addr and wdata at that edge.
- Transitions:
  - IDLE/RESP with accept: go to WAIT and load a counter with WAIT_STATES-1. If WAIT_STATES=0, complete on the same edge and go to RESP.
  - IDLE/RESP without accept: go to IDLE.
  - WAIT: decrement the counter. The edge where it reads 0 is the completion edge; go to RESP.
- Completion edge:
  - Stores update the array.
  - Loads register resp_rdata from the array contents before that edge.
  - resp_err is registered on the same edge.
- Decode (funct3):
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Error conditions (resp_err=1):
  - illegal funct3;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH_WORDS.
- On error:
  - no array write;
  - resp_rdata=0;
  - latency unchanged.
- Little-endian byte lanes:
  - byte index = addr[1:0], halfword index = addr[1].
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes. Unselected lanes are preserved.
- Loads:
  - LB/LH sign-extend bit 7/15 of the selected lane(s).
  - LBU/LHU zero-extend.
  - LW returns the whole word.
- Array contents are not cleared by reset. A word is undefined until written.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0x0, resp_err 0, counter 0.
- Latency: a request accepted at edge k completes at edge k+WAIT_STATES. resp_valid is high only in the cycle after the completion edge.
- Throughput:
  - WAIT_STATES=0: one request per cycle, because ready stays high in RESP.
  - Otherwise: one request per WAIT_STATES+1 cycles.
- Back-to-back store then load to the same word, WAIT_STATES=0: the load sees the new data. The store completes before the load is accepted.
- resp_rdata and resp_err hold their values after the resp_valid pulse until the next completion.
- With req_valid low in RESP, the FSM goes to IDLE and resp_valid drops.
- Inputs are ignored in WAIT. Changing them mid-WAIT has no effect, because captured values are used.
- Reset asserted in WAIT or RESP:
  - the pending request is discarded and no write occurs;
  - outputs return to reset values on that edge.
- Reset has priority over accept and completion on the same edge.

## Test plan
- Reset and idle: hold rst_n=0 for 3 cycles, then release. Require req_ready=1, resp_valid=0, resp_rdata=0x0, resp_err=0.
- Byte-lane stores and sign extension:
  - SW 0x11223344 @0x10, then SB 0x80 @0x11, then SH 0xBEEF @0x12.
  - LW @0x10 → 0xBEEF8044.
  - LB @0x11 → 0xFFFFFF80; LBU @0x11 → 0x00000080.
  - LH @0x12 → 0xFFFFBEEF; LHU @0x12 → 0x0000BEEF.
- Errors:
  - LW @0x2 → resp_err=1, rdata=0.
  - SH @0x5 → resp_err=1, and the word at 0x4 is unchanged.
  - funct3=011 → resp_err=1.
  - LW @DEPTH_WORDS*4 → resp_err=1.
- Wait states, WAIT_STATES=3:
  - A request accepted at edge k gives resp_valid only in cycle k+4.
  - req_ready is low for cycles k+1..k+3.
  - Changing req_addr mid-WAIT does not alter the result.
- Back-to-back, WAIT_STATES=0: SW 0xCAFEF00D @0x20, then LW @0x20 on the next cycle. Require resp_rdata=0xCAFEF00D one cycle after the load is accepted.
- Reset mid-operation, WAIT_STATES=2:
  - Accept SW 0xDEADBEEF @0x30 over a prior 0x00000001.
  - Assert rst_n=0 during WAIT.
  - A subsequent LW @0x30 returns 0x00000001.

Source files
------------

// File: rtl/data_mem_lsu.sv
// data_mem_lsu: word-organised data memory for the MEM stage with a
// valid/ready request port, byte/halfword/word loads and stores
// (little-endian lanes, signed and unsigned loads), programmable wait
// states and error reporting for illegal, misaligned or out-of-range accesses.
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]  cnt;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic        accept;
    logic        complete;
    logic        cur_we;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;

    logic          legal;
    logic          misalign;
    logic          out_range;
    logic          op_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic [3:0]    byte_en;
    logic [31:0]   wr_lanes;

    // Handshake and selection of the operation being completed: while waiting
    // the captured request is used, otherwise (zero wait states) the live one.
    always_comb begin
        accept     = req_valid && req_ready;
        cur_we     = (state == WAIT) ? we_q     : req_we;
        cur_funct3 = (state == WAIT) ? funct3_q : req_funct3;
        cur_addr   = (state == WAIT) ? addr_q   : req_addr;
        cur_wdata  = (state == WAIT) ? wdata_q  : req_wdata;
        if (state == WAIT) begin
            complete = (cnt == 4'd0);
        end else begin
            complete = accept && (WAIT_STATES == 0);
        end
    end

    // Decode of the completing access: legality, alignment, range, load
    // extraction and store byte-lane enables.
    always_comb begin
        if (cur_we) begin
            legal = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010);
        end else begin
            legal = (cur_funct3 == 3'b000) || (cur_funct3 == 3'b001) || (cur_funct3 == 3'b010) ||
                    (cur_funct3 == 3'b100) || (cur_funct3 == 3'b101);
        end
        misalign  = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                    ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
        out_range = |cur_addr[31:AW+2];
        op_err    = !legal || misalign || out_range;
        word_idx  = cur_addr[AW+1:2];
        rd_word   = mem[word_idx];
        byte_sel  = rd_word[{cur_addr[1:0], 3'b000} +: 8];
        half_sel  = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (cur_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = 32'd0;
        endcase

        case (cur_funct3[1:0])
            2'b00: begin
                byte_en  = 4'b0001 << cur_addr[1:0];
                wr_lanes = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                byte_en  = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{cur_wdata[15:0]}};
            end
            default: begin
                byte_en  = 4'b1111;
                wr_lanes = cur_wdata;
            end
        endcase
    end

    // State register; reset returns to IDLE and drops any pending request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept from IDLE/RESP, count down in WAIT.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    next_state = (WAIT_STATES == 0) ? RESP : WAIT;
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs derived purely from the state.
    always_comb begin
        req_ready  = (state != WAIT);
        resp_valid = (state == RESP);
    end

    // Request capture, wait counter and registered response data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            funct3_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                cnt      <= CNT_INIT;
            end else if ((state == WAIT) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            if (complete) begin
                resp_rdata <= (op_err || cur_we) ? 32'd0 : load_data;
                resp_err   <= op_err;
            end
        end
    end

    // Array write on a legal store completion; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && complete && cur_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: exercises three instances (0, 3 and 2 wait states) with
// directed vectors, hand-written timing sequences and random traffic checked
// against a byte-addressed reference model.
module tb_data_mem_lsu;

    localparam int DEPTH = 256;
    localparam int NDUT  = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid  [NDUT];
    logic        req_ready  [NDUT];
    logic        req_we     [NDUT];
    logic [2:0]  req_funct3 [NDUT];
    logic [31:0] req_addr   [NDUT];
    logic [31:0] req_wdata  [NDUT];
    logic        resp_valid [NDUT];
    logic [31:0] resp_rdata [NDUT];
    logic        resp_err   [NDUT];

    int checks = 0;
    int errors = 0;

    logic [7:0] model_mem   [NDUT][DEPTH*4];
    bit         model_known [NDUT][DEPTH*4];

    typedef struct {
        string       name;
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [16];

    data_mem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
    );

    data_mem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
    );

    data_mem_lsu #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
        .req_funct3(req_funct3[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
        .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int ws_of(int d);
        if (d == 0) return 0;
        if (d == 1) return 3;
        return 2;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Reference behaviour: byte-granular memory, access size from funct3,
    // error rules and sign/zero extension computed with plain arithmetic.
    task automatic model_op(int d, bit we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                            output logic [31:0] erd, output bit eerr, output bit known);
        bit  legal;
        int  nb;
        longint val;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        eerr  = !legal || ((addr % nb) != 0) || ((addr / 4) >= DEPTH);
        erd   = 32'd0;
        known = 1'b1;
        if (!eerr) begin
            if (we) begin
                for (int i = 0; i < nb; i++) begin
                    model_mem[d][addr + i]   = 8'((wd >> (8 * i)) & 32'hFF);
                    model_known[d][addr + i] = 1'b1;
                end
            end else begin
                val = 0;
                for (int i = 0; i < nb; i++) begin
                    val = val + (longint'(model_mem[d][addr + i]) << (8 * i));
                    known = known && model_known[d][addr + i];
                end
                if (f3[2] == 1'b0 && nb < 4 && val >= (longint'(1) << (8 * nb - 1))) begin
                    val = val - (longint'(1) << (8 * nb));
                end
                erd = val[31:0];
            end
        end
    endtask

    // One complete request on instance d: waits for the response with a
    // cycle budget and checks the observed latency against the wait states.
    task automatic applyStimulus(int d, bit we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                                 output logic [31:0] rd, output logic er);
        int cycles;
        @(negedge clk);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wd;
        checkOutput("ready_before_accept", 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        cycles = 0;
        while (!resp_valid[d] && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!resp_valid[d]) begin
            checks++;
            errors++;
            $display("[TB] FAIL response_timeout dut=%0d actual=no_resp_valid expected=resp_valid", d);
        end
        checkOutput("latency", 32'(cycles), 32'(ws_of(d)));
        rd = resp_rdata[d];
        er = resp_err[d];
    endtask

    task automatic random_phase(int d, int n);
        logic [31:0] rd, erd, addr, wd;
        logic        er;
        logic [2:0]  f3;
        bit          we, eerr, known;
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            model_op(d, 1'b1, 3'b010, 32'(w * 4), wd, erd, eerr, known);
            applyStimulus(d, 1'b1, 3'b010, 32'(w * 4), wd, rd, er);
            checkOutput("prefill_err", 32'(er), 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                f3 = 3'($urandom_range(0, 7));
            end else begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end
            if ($urandom_range(0, 9) == 0) begin
                addr = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095));
            end else begin
                addr = 32'($urandom_range(0, 63));
            end
            wd = $urandom;
            model_op(d, we, f3, addr, wd, erd, eerr, known);
            applyStimulus(d, we, f3, addr, wd, rd, er);
            checkOutput("rand_err", 32'(er), 32'(eerr));
            if (known) begin
                checkOutput("rand_rdata", rd, erd);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end
    endtask

    initial begin
        logic [31:0] rd, erd;
        logic        er;
        bit          eerr, known;
        logic [31:0] val_a, val_b;

        vecs[0]  = '{"sw_10",      1'b1, 3'b010, 32'h10,  32'h11223344, 32'h0,        1'b0};
        vecs[1]  = '{"sb_11",      1'b1, 3'b000, 32'h11,  32'hAAAAAA80, 32'h0,        1'b0};
        vecs[2]  = '{"sh_12",      1'b1, 3'b001, 32'h12,  32'h1234BEEF, 32'h0,        1'b0};
        vecs[3]  = '{"lw_10",      1'b0, 3'b010, 32'h10,  32'h0,        32'hBEEF8044, 1'b0};
        vecs[4]  = '{"lb_11",      1'b0, 3'b000, 32'h11,  32'h0,        32'hFFFFFF80, 1'b0};
        vecs[5]  = '{"lbu_11",     1'b0, 3'b100, 32'h11,  32'h0,        32'h00000080, 1'b0};
        vecs[6]  = '{"lh_12",      1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFBEEF, 1'b0};
        vecs[7]  = '{"lhu_12",     1'b0, 3'b101, 32'h12,  32'h0,        32'h0000BEEF, 1'b0};
        vecs[8]  = '{"lw_misalign",1'b0, 3'b010, 32'h2,   32'h0,        32'h0,        1'b1};
        vecs[9]  = '{"sw_04",      1'b1, 3'b010, 32'h4,   32'h55667788, 32'h0,        1'b0};
        vecs[10] = '{"sh_misalign",1'b1, 3'b001, 32'h5,   32'h0000FFFF, 32'h0,        1'b1};
        vecs[11] = '{"lw_04_kept", 1'b0, 3'b010, 32'h4,   32'h0,        32'h55667788, 1'b0};
        vecs[12] = '{"illegal_011",1'b0, 3'b011, 32'h0,   32'h0,        32'h0,        1'b1};
        vecs[13] = '{"lw_range",   1'b0, 3'b010, 32'(DEPTH * 4), 32'h0, 32'h0,        1'b1};
        vecs[14] = '{"lb_13",      1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFBE, 1'b0};
        vecs[15] = '{"lhu_10",     1'b0, 3'b101, 32'h10,  32'h0,        32'h00008044, 1'b0};

        rst_n = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_funct3[d] = 3'd0;
            req_addr[d]   = 32'd0;
            req_wdata[d]  = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            checkOutput("reset_ready", 32'(req_ready[d]), 32'd1);
            checkOutput("reset_valid", 32'(resp_valid[d]), 32'd0);
            checkOutput("reset_rdata", resp_rdata[d], 32'd0);
            checkOutput("reset_err",   32'(resp_err[d]), 32'd0);
        end

        // Directed vectors on the zero-wait instance.
        for (int i = 0; i < 16; i++) begin
            model_op(0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, erd, eerr, known);
            applyStimulus(0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er);
            checkOutput({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
            checkOutput({vecs[i].name, "_err"}, 32'(er), 32'(vecs[i].exp_err));
        end

        random_phase(0, 200);
        random_phase(1, 60);

        // Wait-state timing and mid-wait input changes on the 3-wait instance.
        val_a = 32'hA5A50F0F;
        val_b = 32'h3C3C1234;
        applyStimulus(1, 1'b1, 3'b010, 32'h40, val_a, rd, er);
        applyStimulus(1, 1'b1, 3'b010, 32'h44, val_b, rd, er);
        @(negedge clk);
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b0;
        req_funct3[1] = 3'b010;
        req_addr[1]   = 32'h40;
        @(posedge clk);
        #1;
        req_addr[1]   = 32'h44;
        req_we[1]     = 1'b1;
        req_wdata[1]  = 32'hFFFFFFFF;
        for (int c = 1; c <= 3; c++) begin
            checkOutput("wait_ready_low", 32'(req_ready[1]), 32'd0);
            checkOutput("wait_no_resp", 32'(resp_valid[1]), 32'd0);
            @(posedge clk);
            #1;
        end
        checkOutput("wait_resp_valid", 32'(resp_valid[1]), 32'd1);
        checkOutput("wait_rdata", resp_rdata[1], val_a);
        checkOutput("wait_ready_back", 32'(req_ready[1]), 32'd1);
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("resp_pulse_drops", 32'(resp_valid[1]), 32'd0);
        checkOutput("rdata_holds", resp_rdata[1], val_a);
        applyStimulus(1, 1'b0, 3'b010, 32'h44, 32'h0, rd, er);
        checkOutput("wait_b_unchanged", rd, val_b);

        // Store immediately followed by a load to the same word, zero waits.
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_we[0]     = 1'b1;
        req_funct3[0] = 3'b010;
        req_addr[0]   = 32'h20;
        req_wdata[0]  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        checkOutput("b2b_store_resp", 32'(resp_valid[0]), 32'd1);
        checkOutput("b2b_store_err", 32'(resp_err[0]), 32'd0);
        req_we[0] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        checkOutput("b2b_load_resp", 32'(resp_valid[0]), 32'd1);
        checkOutput("b2b_load_rdata", resp_rdata[0], 32'hCAFEF00D);

        // Reset during WAIT discards the pending store.
        applyStimulus(2, 1'b1, 3'b010, 32'h30, 32'h00000001, rd, er);
        @(negedge clk);
        req_valid[2]  = 1'b1;
        req_we[2]     = 1'b1;
        req_funct3[2] = 3'b010;
        req_addr[2]   = 32'h30;
        req_wdata[2]  = 32'hDEADBEEF;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        checkOutput("rst_mid_in_wait", 32'(req_ready[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_ready", 32'(req_ready[2]), 32'd1);
        checkOutput("rst_mid_valid", 32'(resp_valid[2]), 32'd0);
        checkOutput("rst_mid_err", 32'(resp_err[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        applyStimulus(2, 1'b0, 3'b010, 32'h30, 32'h0, rd, er);
        checkOutput("rst_mid_no_write", rd, 32'h00000001);
        checkOutput("rst_mid_load_err", 32'(er), 32'd0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
